// File: rtl/mod_reg_pkg.sv
// Shared types for the alarm-clock digit registers: the operation encoding
// and the priority decode that picks one operation per clock edge.
package mod_reg_pkg;

  typedef enum logic [2:0] {
    OP_HOLD,
    OP_CLR,
    OP_LD,
    OP_INC,
    OP_DEC
  } op_t;

  // CLR beats LD beats counting; INC and DEC together cancel to a hold.
  function automatic op_t decode_op(input logic en, input logic clr, input logic ld,
                                    input logic inc, input logic dec);
    op_t op;
    op = OP_HOLD;
    if (en) begin
      if (clr)             op = OP_CLR;
      else if (ld)         op = OP_LD;
      else if (inc && !dec) op = OP_INC;
      else if (dec && !inc) op = OP_DEC;
    end
    return op;
  endfunction

endpackage

// File: rtl/en_reg.sv
// WIDTH-bit enabled register with asynchronous active-low clear to RESET_VAL.
module en_reg #(
  parameter int                WIDTH     = 4,
  parameter logic [WIDTH-1:0]  RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_ni,
  input  logic             en_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] q_q;

  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni)   q_q <= RESET_VAL;
    else if (en_i) q_q <= d_i;
  end

  assign q_o = q_q;

endmodule

// File: rtl/mod_en_reg.sv
// Modulo-MODULUS digit register: clear, clamped load, wrapping up/down count,
// registered carry/borrow pulses, sticky load-range error and a cascade TC.
module mod_en_reg
  import mod_reg_pkg::*;
#(
  parameter int WIDTH     = 4,
  parameter int MODULUS   = 10,
  parameter int RESET_VAL = 0
) (
  input  logic             clk,
  input  logic             CLRN,
  input  logic             EN,
  input  logic             CLR,
  input  logic             LD,
  input  logic [WIDTH-1:0] D,
  input  logic             INC,
  input  logic             DEC,
  output logic [WIDTH-1:0] Q,
  output logic             TC,
  output logic             CO,
  output logic             BO,
  output logic             ERR
);

  generate
    if (MODULUS < 2 || MODULUS > (1 << WIDTH) || RESET_VAL < 0 || RESET_VAL >= MODULUS) begin : g_bad_param
      $error("mod_en_reg: illegal MODULUS/RESET_VAL for this WIDTH");
    end
  endgenerate

  localparam logic [WIDTH-1:0] MAX_Q = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH-1:0] RST_Q = WIDTH'(RESET_VAL);
  // MODULUS itself may equal 2**WIDTH, so compares against it need the extra bit.
  localparam logic [WIDTH:0]   MOD_X = (WIDTH+1)'(MODULUS);

  op_t              op;
  logic [WIDTH-1:0] q_d;
  logic [WIDTH:0]   q_ext;
  logic [WIDTH:0]   inc_x;
  logic             at_max;
  logic             at_zero;
  logic             d_over;
  logic             co_d, bo_d, err_d;
  logic             co_q, bo_q, err_q;

  assign op      = decode_op(EN, CLR, LD, INC, DEC);
  assign q_ext   = {1'b0, Q};
  assign inc_x   = q_ext + (WIDTH+1)'(1);
  assign at_max  = (inc_x == MOD_X);
  assign at_zero = (Q == '0);
  assign d_over  = ({1'b0, D} >= MOD_X);

  always_comb begin
    q_d   = Q;
    co_d  = 1'b0;
    bo_d  = 1'b0;
    err_d = err_q;
    case (op)
      OP_CLR: begin
        q_d   = '0;
        err_d = 1'b0;
      end
      OP_LD: begin
        if (d_over) begin
          q_d   = MAX_Q;
          err_d = 1'b1;
        end else begin
          q_d = D;
        end
      end
      OP_INC: begin
        q_d  = at_max ? '0 : inc_x[WIDTH-1:0];
        co_d = at_max;
      end
      OP_DEC: begin
        q_d  = at_zero ? MAX_Q : Q - WIDTH'(1);
        bo_d = at_zero;
      end
      default: ;
    endcase
  end

  en_reg #(
    .WIDTH     (WIDTH),
    .RESET_VAL (RST_Q)
  ) u_store (
    .clk    (clk),
    .rst_ni (CLRN),
    .en_i   (EN),
    .d_i    (q_d),
    .q_o    (Q)
  );

  always_ff @(posedge clk or negedge CLRN) begin
    if (!CLRN) begin
      co_q  <= 1'b0;
      bo_q  <= 1'b0;
      err_q <= 1'b0;
    end else begin
      co_q  <= co_d;
      bo_q  <= bo_d;
      err_q <= err_d;
    end
  end

  // Terminal count looks only at this digit's inputs; the next digit's INC hangs off it.
  assign TC  = EN & INC & ~DEC & ~CLR & ~LD & at_max;
  assign CO  = co_q;
  assign BO  = bo_q;
  assign ERR = err_q;

endmodule

// File: tb/tb_mod_en_reg.sv
// Bench for mod_en_reg: a mod-10 digit cascaded into a mod-6 digit, plus a
// WIDTH=5 mod-24 instance, all checked against an integer reference model.
module tb_mod_en_reg;

  typedef struct {
    int q;
    bit co;
    bit bo;
    bit err;
  } model_t;

  typedef struct {
    int e, c, l, i, dn, dv;
  } stim_t;

  logic       clk, rst_n;
  logic       en, clr, ld, inc, dec;
  logic       zero;
  logic [4:0] d5;
  logic [3:0] dh;
  logic [3:0] q_a, q_h;
  logic [4:0] q_w;
  logic       tc_a, co_a, bo_a, err_a;
  logic       tc_h, co_h, bo_h, err_h;
  logic       tc_w, co_w, bo_w, err_w;

  model_t m_a, m_h, m_w;
  int     n_tests, n_fail;

  mod_en_reg u_dut (
    .clk(clk), .CLRN(rst_n), .EN(en), .CLR(clr), .LD(ld), .D(d5[3:0]),
    .INC(inc), .DEC(dec), .Q(q_a), .TC(tc_a), .CO(co_a), .BO(bo_a), .ERR(err_a)
  );

  mod_en_reg #(.WIDTH(4), .MODULUS(6), .RESET_VAL(0)) u_hi (
    .clk(clk), .CLRN(rst_n), .EN(en), .CLR(clr), .LD(ld), .D(dh),
    .INC(tc_a), .DEC(zero), .Q(q_h), .TC(tc_h), .CO(co_h), .BO(bo_h), .ERR(err_h)
  );

  mod_en_reg #(.WIDTH(5), .MODULUS(24), .RESET_VAL(12)) u_w5 (
    .clk(clk), .CLRN(rst_n), .EN(en), .CLR(clr), .LD(ld), .D(d5),
    .INC(inc), .DEC(dec), .Q(q_w), .TC(tc_w), .CO(co_w), .BO(bo_w), .ERR(err_w)
  );

  always #5 clk = ~clk;

  function automatic model_t model_next(model_t s, int m, bit e, bit c, bit l, bit i, bit dn, int dv);
    model_t n;
    n = s;
    n.co = 0;
    n.bo = 0;
    if (!e) return n;
    if (c) begin
      n.q = 0;
      n.err = 0;
    end else if (l) begin
      if (dv >= m) begin
        n.q = m - 1;
        n.err = 1;
      end else n.q = dv;
    end else if (i && !dn) begin
      n.q  = (s.q + 1) % m;
      n.co = (n.q == 0);
    end else if (dn && !i) begin
      n.q  = (s.q + m - 1) % m;
      n.bo = (s.q == 0);
    end
    return n;
  endfunction

  function automatic bit exp_tc(model_t s, int m, bit e, bit c, bit l, bit i, bit dn);
    return e && i && !dn && !c && !l && (s.q == m - 1);
  endfunction

  function automatic model_t model_reset(int rv);
    model_t n;
    n.q = rv; n.co = 0; n.bo = 0; n.err = 0;
    return n;
  endfunction

  task automatic set(input stim_t s, input int dhv);
    @(negedge clk);
    en  = (s.e != 0);
    clr = (s.c != 0);
    ld  = (s.l != 0);
    inc = (s.i != 0);
    dec = (s.dn != 0);
    d5  = 5'(s.dv);
    dh  = 4'(dhv);
    #1;
  endtask

  task automatic tick();
    bit ta;
    @(posedge clk);
    ta  = exp_tc(m_a, 10, en, clr, ld, inc, dec);
    m_a = model_next(m_a, 10, en, clr, ld, inc, dec, int'(d5[3:0]));
    m_h = model_next(m_h, 6, en, clr, ld, ta, 1'b0, int'(dh));
    m_w = model_next(m_w, 24, en, clr, ld, inc, dec, int'(d5));
    #1;
  endtask

  task automatic test_reset();
    stim_t s;
    rst_n = 0;
    m_a = model_reset(0); m_h = model_reset(0); m_w = model_reset(12);
    repeat (2) @(posedge clk);
    #1;
    n_tests++;
    if ({q_a, co_a, bo_a, err_a} !== 7'b0000_000 || q_w !== 5'd12 || q_h !== 4'd0) begin
      n_fail++;
      $display("FAIL reset_state got q_a=%0d co/bo/err=%b%b%b q_w=%0d q_h=%0d want 0 000 12 0", q_a, co_a, bo_a, err_a, q_w, q_h);
    end
    @(negedge clk);
    rst_n = 1;
    s = '{1, 0, 0, 1, 0, 0};
    set(s, 0);
    repeat (7) tick();
    n_tests++;
    if (q_a !== 4'(m_a.q) || m_a.q != 7) begin
      n_fail++;
      $display("FAIL reset_precount got q=%0d want 7", q_a);
    end
    #2 rst_n = 0;
    #1;
    m_a = model_reset(0); m_h = model_reset(0); m_w = model_reset(12);
    n_tests++;
    if ({q_a, co_a, bo_a, err_a} !== 7'b0000_000 || q_w !== 5'd12) begin
      n_fail++;
      $display("FAIL reset_async got q=%0d co/bo/err=%b%b%b q_w=%0d want 0 000 12", q_a, co_a, bo_a, err_a, q_w);
    end
    @(negedge clk);
    rst_n = 1;
    tick();
    n_tests++;
    if (q_a !== 4'd1 || q_w !== 5'd13) begin
      n_fail++;
      $display("FAIL reset_resume got q=%0d q_w=%0d want 1 13", q_a, q_w);
    end
  endtask

  task automatic test_up_wrap();
    stim_t s;
    s = '{1, 1, 0, 0, 0, 0};
    set(s, 0);
    tick();
    s = '{1, 0, 0, 1, 0, 0};
    for (int k = 0; k < 11; k++) begin
      set(s, 0);
      n_tests++;
      if (tc_a !== (m_a.q == 9)) begin
        n_fail++;
        $display("FAIL up_wrap_tc step=%0d got %b want %b", k, tc_a, (m_a.q == 9));
      end
      tick();
      n_tests++;
      if (q_a !== 4'((k + 1) % 10) || co_a !== (k == 9) || {q_a, co_a, bo_a, err_a} !== {4'(m_a.q), m_a.co, m_a.bo, m_a.err}) begin
        n_fail++;
        $display("FAIL up_wrap step=%0d got q=%0d co=%b want q=%0d co=%b", k, q_a, co_a, (k + 1) % 10, (k == 9));
      end
    end
  endtask

  task automatic test_down_conflict();
    stim_t tbl[9];
    tbl = '{'{1,1,0,0,0,0}, '{1,0,0,0,1,0}, '{1,0,0,0,1,0}, '{1,0,0,1,1,0}, '{0,0,0,1,0,0},
            '{1,0,1,0,0,9}, '{0,0,0,1,0,0}, '{1,0,0,1,0,0}, '{1,0,0,0,0,0}};
    foreach (tbl[k]) begin
      set(tbl[k], 0);
      n_tests++;
      if (tc_a !== exp_tc(m_a, 10, en, clr, ld, inc, dec)) begin
        n_fail++;
        $display("FAIL down_tc step=%0d got %b want %b", k, tc_a, exp_tc(m_a, 10, en, clr, ld, inc, dec));
      end
      tick();
      n_tests++;
      if ({q_a, co_a, bo_a, err_a} !== {4'(m_a.q), m_a.co, m_a.bo, m_a.err}) begin
        n_fail++;
        $display("FAIL down_conflict step=%0d got q=%0d co/bo/err=%b%b%b want q=%0d %b%b%b",
                 k, q_a, co_a, bo_a, err_a, m_a.q, m_a.co, m_a.bo, m_a.err);
      end
    end
  endtask

  task automatic test_load_priority();
    stim_t tbl[7];
    tbl = '{'{1,0,1,0,0,6}, '{1,0,1,0,0,13}, '{1,0,0,1,0,0}, '{1,0,0,1,0,0},
            '{0,1,0,0,0,0}, '{1,1,1,0,0,7}, '{1,0,1,1,0,3}};
    foreach (tbl[k]) begin
      set(tbl[k], 0);
      tick();
      n_tests++;
      if ({q_a, co_a, bo_a, err_a} !== {4'(m_a.q), m_a.co, m_a.bo, m_a.err}) begin
        n_fail++;
        $display("FAIL load_priority step=%0d got q=%0d co/bo/err=%b%b%b want q=%0d %b%b%b",
                 k, q_a, co_a, bo_a, err_a, m_a.q, m_a.co, m_a.bo, m_a.err);
      end
    end
  endtask

  task automatic test_cascade();
    stim_t s;
    s = '{1, 0, 1, 0, 0, 9};
    set(s, 5);
    tick();
    n_tests++;
    if (q_a !== 4'd9 || q_h !== 4'd5) begin
      n_fail++;
      $display("FAIL cascade_load got lo=%0d hi=%0d want 9 5", q_a, q_h);
    end
    s = '{1, 0, 0, 1, 0, 0};
    set(s, 0);
    n_tests++;
    if (tc_a !== 1'b1 || tc_h !== 1'b1) begin
      n_fail++;
      $display("FAIL cascade_tc got lo_tc=%b hi_tc=%b want 1 1", tc_a, tc_h);
    end
    tick();
    n_tests++;
    if (q_a !== 4'd0 || q_h !== 4'd0 || co_h !== 1'b1 || co_a !== 1'b1 || q_h !== 4'(m_h.q)) begin
      n_fail++;
      $display("FAIL cascade_wrap got lo=%0d hi=%0d lo_co=%b hi_co=%b want 0 0 1 1", q_a, q_h, co_a, co_h);
    end
  endtask

  task automatic test_sweep();
    stim_t tbl[6];
    tbl = '{'{1,1,0,0,0,0}, '{1,0,1,0,0,23}, '{1,0,0,1,0,0}, '{1,0,0,0,1,0},
            '{1,0,1,0,0,31}, '{1,0,1,0,0,24}};
    foreach (tbl[k]) begin
      set(tbl[k], 0);
      n_tests++;
      if (tc_w !== exp_tc(m_w, 24, en, clr, ld, inc, dec)) begin
        n_fail++;
        $display("FAIL sweep_tc step=%0d got %b want %b", k, tc_w, exp_tc(m_w, 24, en, clr, ld, inc, dec));
      end
      tick();
      n_tests++;
      if ({q_w, co_w, bo_w, err_w} !== {5'(m_w.q), m_w.co, m_w.bo, m_w.err}) begin
        n_fail++;
        $display("FAIL sweep step=%0d got q=%0d co/bo/err=%b%b%b want q=%0d %b%b%b",
                 k, q_w, co_w, bo_w, err_w, m_w.q, m_w.co, m_w.bo, m_w.err);
      end
    end
  endtask

  task automatic test_random();
    stim_t s;
    bit    ta;
    for (int k = 0; k < 400; k++) begin
      s.e  = ($urandom_range(0, 9) != 0) ? 1 : 0;
      s.c  = ($urandom_range(0, 19) == 0) ? 1 : 0;
      s.l  = ($urandom_range(0, 9) == 0) ? 1 : 0;
      s.i  = int'($urandom_range(0, 1));
      s.dn = ($urandom_range(0, 3) == 0) ? 1 : 0;
      s.dv = int'($urandom_range(0, 31));
      set(s, int'($urandom_range(0, 15)));
      ta = exp_tc(m_a, 10, en, clr, ld, inc, dec);
      n_tests++;
      if (tc_a !== ta || tc_h !== exp_tc(m_h, 6, en, clr, ld, ta, 1'b0) || tc_w !== exp_tc(m_w, 24, en, clr, ld, inc, dec)) begin
        n_fail++;
        $display("FAIL random_tc cyc=%0d got %b%b%b want %b%b%b", k, tc_a, tc_h, tc_w,
                 ta, exp_tc(m_h, 6, en, clr, ld, ta, 1'b0), exp_tc(m_w, 24, en, clr, ld, inc, dec));
      end
      tick();
      n_tests++;
      if ({q_a, co_a, bo_a, err_a} !== {4'(m_a.q), m_a.co, m_a.bo, m_a.err} ||
          {q_h, co_h, bo_h, err_h} !== {4'(m_h.q), m_h.co, m_h.bo, m_h.err} ||
          {q_w, co_w, bo_w, err_w} !== {5'(m_w.q), m_w.co, m_w.bo, m_w.err}) begin
        n_fail++;
        $display("FAIL random cyc=%0d got a=%0d/%b%b%b h=%0d/%b%b%b w=%0d/%b%b%b want a=%0d/%b%b%b h=%0d/%b%b%b w=%0d/%b%b%b",
                 k, q_a, co_a, bo_a, err_a, q_h, co_h, bo_h, err_h, q_w, co_w, bo_w, err_w,
                 m_a.q, m_a.co, m_a.bo, m_a.err, m_h.q, m_h.co, m_h.bo, m_h.err, m_w.q, m_w.co, m_w.bo, m_w.err);
      end
    end
  endtask

  initial begin
    clk = 0; rst_n = 0; zero = 0;
    en = 0; clr = 0; ld = 0; inc = 0; dec = 0; d5 = '0; dh = '0;
    n_tests = 0; n_fail = 0;
    test_reset();
    test_up_wrap();
    test_down_conflict();
    test_load_priority();
    test_cascade();
    test_sweep();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
